// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one signed MAC walks a circular sample history
// against a writable coefficient bank, producing one filter output per accepted sample.
module fir_mac_sequencer #(
    parameter int unsigned NTAPS = 74,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned AW    = 39
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_sample,
    input  logic                 coef_we,
    input  logic [6:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    output logic signed [AW-1:0] out_data,
    output logic                 busy
);

    localparam int unsigned PW = DW + CW;
    localparam int unsigned KW = 7;
    localparam logic [KW-1:0] LAST = KW'(NTAPS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MAC  = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic signed [DW-1:0] hist [NTAPS];
    logic signed [CW-1:0] coef [NTAPS];
    logic signed [AW-1:0] acc;
    logic [KW-1:0]        k;
    logic [KW-1:0]        rd_ptr;
    logic [KW-1:0]        wr_ptr;
    logic                 accept;
    logic                 last_tap;
    logic                 coef_wr;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sum;

    // Next-state, handshake and MAC arithmetic
    always_comb begin
        state_nxt = state;
        in_ready  = ena & ~rst & (state == IDLE);
        busy      = (state == MAC);
        accept    = in_valid & in_ready;
        last_tap  = (state == MAC) && (k == LAST);
        coef_wr   = coef_we & ena & (state == IDLE) & (coef_addr <= LAST);
        prod      = PW'(hist[rd_ptr]) * PW'(coef[k]);
        sum       = acc + AW'(prod);
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Datapath, memories and result register; everything freezes while ena is low
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
            acc       <= '0;
            k         <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (ena) begin
            out_valid <= last_tap;
            if (coef_wr) begin
                coef[coef_addr] <= coef_data;
            end
            if (accept) begin
                hist[wr_ptr] <= in_sample;
                rd_ptr       <= wr_ptr;
                k            <= '0;
                acc          <= '0;
            end
            if (state == MAC) begin
                acc    <= sum;
                rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
                k      <= last_tap ? '0 : k + 1'b1;
                if (last_tap) begin
                    out_data <= sum;
                    wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer with hand-computed expected outputs.
module tb_fir_mac_sequencer;

    localparam int unsigned NTAPS = 74;
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 16;
    localparam int unsigned AW    = 39;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ena;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_sample;
    logic                 coef_we;
    logic [6:0]           coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [AW-1:0] out_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int lat;
    logic signed [AW-1:0] y;

    fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 7'(addr);
        coef_data = 16'(data);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Returns at the negedge just after the accepting edge
    task automatic accept_sample(input int x, input logic we, input int addr, input int data);
        int n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'(x);
        coef_we   = we;
        coef_addr = 7'(addr);
        coef_data = 16'(data);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        in_sample = '0;
    endtask

    // Counts negedges from the accept until out_valid, optionally dropping ena for a window
    task automatic wait_result(input int stall_at, input int stall_len, output int l, output logic signed [AW-1:0] r);
        l = 0;
        while (!out_valid && l < 400) begin
            if (stall_len > 0 && l == stall_at) ena = 1'b0;
            if (stall_len > 0 && l == stall_at + stall_len) ena = 1'b1;
            @(negedge clk);
            l++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
        r = out_data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc_t[$];
        int ov_t[$];
        int naccept;
        int nov;

        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_sample = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Impulse response with coef[k] = k+1
        for (int i = 0; i < int'(NTAPS); i++) write_coef(i, i + 1);
        for (int n = 0; n <= int'(NTAPS); n++) begin
            accept_sample((n == 0) ? 1 : 0, 1'b0, 0, 0);
            if (n == 0) check("busy_in_mac", busy, 1);
            wait_result(0, 0, lat, y);
            check($sformatf("impulse_%0d", n), y, (n < int'(NTAPS)) ? n + 1 : 0);
            if (n == 0) begin
                check("latency", lat, 74);
                @(negedge clk);
                check("pulse_width", out_valid, 0);
            end
        end

        // Back-to-back handshake with in_valid held high
        naccept = 0;
        @(negedge clk);
        in_valid = 1'b1; in_sample = '0;
        for (int t = 0; t < 900; t++) begin
            if (out_valid) ov_t.push_back(t);
            if (in_ready && in_valid && naccept < 10) begin
                acc_t.push_back(t);
                naccept++;
            end
            @(negedge clk);
            if (naccept == 10) in_valid = 1'b0;
        end
        check("hs_accepts", acc_t.size(), 10);
        check("hs_results", ov_t.size(), 10);
        check("hs_first_accept", acc_t[0], 0);
        for (int i = 0; i < acc_t.size() && i < ov_t.size(); i++)
            check($sformatf("hs_latency_%0d", i), ov_t[i] - acc_t[i], 75);
        for (int i = 1; i < acc_t.size(); i++)
            check($sformatf("hs_period_%0d", i), acc_t[i] - acc_t[i-1], 75);
        check("hs_out_data", out_data, 0);

        // ena low for 10 cycles mid-MAC; history is all zero apart from this sample
        accept_sample(7, 1'b0, 0, 0);
        wait_result(30, 10, lat, y);
        check("stall_latency", lat, 84);
        check("stall_data", y, 7);
        ena = 1'b0;
        @(negedge clk);
        check("ov_hold_ena0", out_valid, 1);
        check("ready_ena0", in_ready, 0);
        ena = 1'b1;
        @(negedge clk);
        check("ov_clear_ena1", out_valid, 0);

        // Reset 30 cycles into a MAC sequence
        accept_sample(5, 1'b0, 0, 0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        nov = 0;
        for (int t = 0; t < 100; t++) begin
            if (out_valid) nov++;
            @(negedge clk);
        end
        check("abort_no_valid", nov, 0);
        check("abort_out_data", out_data, 0);
        for (int i = 0; i < int'(NTAPS); i++) write_coef(i, i + 1);
        for (int n = 0; n < 3; n++) begin
            accept_sample((n == 0) ? 1 : 0, 1'b0, 0, 0);
            wait_result(0, 0, lat, y);
            check($sformatf("reimpulse_%0d", n), y, n + 1);
        end

        // Coefficient write gating; history newest-first is now 0,0,1
        accept_sample(10, 1'b0, 0, 0);
        write_coef(0, 5);
        wait_result(0, 0, lat, y);
        check("cfg_mac_seq", y, 14);
        write_coef(100, 9);
        accept_sample(2, 1'b0, 0, 0);
        wait_result(0, 0, lat, y);
        check("cfg_dropped", y, 27);
        accept_sample(3, 1'b1, 1, 100);
        wait_result(0, 0, lat, y);
        check("cfg_same_cycle", y, 239);

        // Full-scale accumulation
        for (int i = 0; i < int'(NTAPS); i++) write_coef(i, -32768);
        for (int n = 0; n < int'(NTAPS); n++) begin
            accept_sample(-32768, 1'b0, 0, 0);
            wait_result(0, 0, lat, y);
        end
        check("full_scale_pos", y, 64'sd79456894976);
        for (int n = 0; n < int'(NTAPS); n++) begin
            accept_sample(32767, 1'b0, 0, 0);
            wait_result(0, 0, lat, y);
        end
        check("full_scale_neg", y, -64'sd79454470144);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed controller for the low-pass FIR filter. It drives one signed 16x16 multiply-accumulate unit over a circular sample history and a writable coefficient bank, so the fully parallel 74-multiplier datapath is no longer needed. It sits between the sample source (valid/ready) and the downstream consumer (registered result plus valid pulse). It also owns coefficient configuration.

## Interface
- NTAPS, 74, number of taps; also the sample-history depth
- DW, 16, signed sample width
- CW, 16, signed coefficient width
- AW, 39, accumulator/output width = DW+CW+$clog2(NTAPS)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  global clock enable; when 0, every register holds
- in_valid  in  1  in_sample is presented
- in_ready  out  1  block accepts a sample this cycle
- in_sample  in  DW  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  7  tap index to write
- coef_data  in  CW  signed coefficient value
- out_valid  out  1  out_data is a new result
- out_data  out  AW  signed filter output
- busy  out  1  MAC sequence in progress

## Operation
- Storage:
  - NTAPS x DW sample history, circular, write pointer wr_ptr.
  - NTAPS x CW coefficient bank.
  - AW-bit accumulator acc, tap counter k (0..NTAPS-1), read pointer rd_ptr.
- FSM states: IDLE, MAC.
- IDLE:
  - in_ready = ena.
  - On in_valid & in_ready: hist[wr_ptr] <= in_sample, rd_ptr <= wr_ptr, k <= 0, acc <= 0, go to MAC.
  - in_sample is sampled only on the accepting edge.
- MAC, one tap per enabled cycle:
  - prod = $signed(hist[rd_ptr]) * $signed(coef[k]), 32 bits, sign-extended to AW.
  - acc <= acc + prod.
  - rd_ptr decrements, wrapping 0 -> NTAPS-1.
  - k increments.
- Last tap (k == NTAPS-1):
  - out_data <= acc + prod, out_valid <= 1.
  - wr_ptr advances, wrapping NTAPS-1 -> 0.
  - Go to IDLE.
- Result definition: y[n] = sum over k of coef[k]*x[n-k], with x[n] the newest sample.
- Arithmetic: two's complement, wrap mod 2^AW. This cannot overflow at the defaults, since 74*2^30 < 2^38.
- Coefficient writes:
  - Take effect only in IDLE, with ena=1 and coef_addr < NTAPS.
  - Writes in MAC, and writes with coef_addr >= NTAPS, are silently dropped.
  - A write and a sample acceptance in the same IDLE cycle are both performed; the new coefficient applies to that sequence.
- busy = (state == MAC).
- out_data holds its last value until the next result.

## Timing
- Reset values:
  - state IDLE, in_ready 0 during reset, out_valid 0, out_data 0, busy 0.
  - acc 0, k 0, wr_ptr 0, rd_ptr 0.
  - All history entries 0, all coefficients 0.
- Reset mid-MAC aborts the sequence: no out_valid, and history and coefficients are cleared.
- Latency: acceptance on edge E0; out_valid is high in the cycle after edge E0+NTAPS, assuming ena stays 1.
- Throughput: one sample per NTAPS+1 cycles. in_ready rises in the same cycle out_valid is high, so back-to-back samples give a period of exactly NTAPS+1.
- out_valid is a one-cycle pulse. It clears on the next edge with ena=1; while ena=0 it holds.
- ena=0 freezes FSM, counters, acc, memories and outputs. in_ready is 0 and no sample is accepted. Latency stretches by the number of disabled cycles, and the result is unchanged.
- in_ready does not depend combinationally on in_valid.

## Test plan
- Impulse: coef[k]=k+1, feed 1 then 0,0,0... -> successive out_data = 1,2,3,...,74, then 0.
- Handshake and latency: in_valid held 1 with 10 samples -> in_ready high 1 cycle in every 75. Each out_valid arrives exactly 74 cycles after its accept edge, one pulse per sample.
- Full scale: all coefs and all samples -32768, after 74 samples -> out_data = 79456894976. Stream of +32767 samples with coef -32768 -> -79454470144 (no wrap).
- Config gating:
  - Write coef[0]=5 during MAC -> ignored.
  - coef_addr=100 in IDLE -> ignored.
  - Write in IDLE -> used by the next accepted sample.
- Reset at cycle 30 of MAC -> no out_valid. in_ready is 1 in the first cycle after reset deasserts, and the next impulse reproduces the step-1 behaviour from zero history.
- ena low for 10 cycles mid-MAC -> out_valid arrives 84 cycles after the accept edge, with the same out_data as an uninterrupted run.
